// File: rtl/p65816_mcode_seq_pkg.sv
// Shared types for the 65C816 microcode sequencer: microinstruction word,
// STATE_CTRL codes, interrupt kinds and sequencer FSM states.
package p65816_mcode_seq_pkg;

  typedef enum logic [2:0] {
    SC_NEXT    = 3'd0,
    SC_END     = 3'd1,
    SC_SKIP_W8 = 3'd2,
    SC_SKIP_DL = 3'd3,
    SC_BRANCH  = 3'd4,
    SC_WAI     = 3'd5,
    SC_STP     = 3'd6,
    SC_RSVD    = 3'd7
  } StateCtrl_e;

  typedef enum logic [1:0] {
    INT_NONE  = 2'd0,
    INT_IRQ   = 2'd1,
    INT_NMI   = 2'd2,
    INT_RESET = 2'd3
  } IntType_e;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_STOP = 2'd2
  } SeqState_e;

  localparam int MC_W = 55;

  // STATE_CTRL sits in the low bits; everything above it fans out to the datapath.
  typedef struct packed {
    logic [MC_W-4:0] datapath;
    StateCtrl_e      STATE_CTRL;
  } MCode_r;

  localparam MCode_r MC_NOP = '{datapath: '0, STATE_CTRL: SC_NEXT};

endpackage

// File: rtl/p65816_int_latch.sv
// NMI falling-edge detector and latch plus interrupt priority selection
// (NMI over IRQ; IRQ masked by P.I except as a WAI wake-up source).
module p65816_int_latch
  import p65816_mcode_seq_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     nmi_n,
  input  logic     irq_n,
  input  logic     i_flag,
  input  logic     take_nmi,
  output IntType_e int_sel,
  output logic     wake
);

  logic nmi_prev;
  logic nmi_latch;

  // A fresh edge in the same cycle as the NMI being taken keeps the latch set.
  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_prev  <= 1'b1;
      nmi_latch <= 1'b0;
    end else begin
      nmi_prev  <= nmi_n;
      nmi_latch <= (nmi_prev & ~nmi_n) | (nmi_latch & ~take_nmi);
    end
  end

  always_comb begin
    int_sel = INT_NONE;
    if (nmi_latch)
      int_sel = INT_NMI;
    else if (!irq_n && !i_flag)
      int_sel = INT_IRQ;
  end

  assign wake = nmi_latch | ~irq_n;

endmodule

// File: rtl/p65816_mcode_seq.sv
// Microcode sequencer: steps {IR, STEP} through the microcode ROM according to
// each word's STATE_CTRL. WAI/STP support is built only with P65816_WAI_STP_EN.
module p65816_mcode_seq
  import p65816_mcode_seq_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CE,
  input  logic              RDY,
  input  logic [7:0]        DATA_IN,
  input  MCode_r            MC_IN,
  input  logic              W8,
  input  logic              DL_NZ,
  input  logic              BR_TAKEN,
  input  logic              NMI_N,
  input  logic              IRQ_N,
  input  logic              I_FLAG,
  output logic [ADDR_W-1:0] MA,
  output MCode_r            MC,
  output logic [7:0]        IR,
  output logic [3:0]        STEP,
  output logic              SYNC,
  output logic [1:0]        INT_TYPE,
  output logic              WAITING,
  output logic              HALTED
);

  SeqState_e  state, state_n;
  IntType_e   int_type, int_n, int_sel;
  logic [7:0] ir_n;
  logic [3:0] step_n;
  logic [4:0] sum;
  logic       advance, fetch, go_wait, go_stop, take_nmi, wake;

  p65816_int_latch u_int_latch (
    .clk      (CLK),
    .rst      (RST),
    .nmi_n    (NMI_N),
    .irq_n    (IRQ_N),
    .i_flag   (I_FLAG),
    .take_nmi (take_nmi),
    .int_sel  (int_sel),
    .wake     (wake)
  );

  // Next {IR, STEP} is computed here so MA can present it to the registered ROM.
  always_comb begin
    advance  = CE & RDY;
    sum      = {1'b0, STEP} + 5'd1;
    fetch    = 1'b0;
    go_wait  = 1'b0;
    go_stop  = 1'b0;
    take_nmi = 1'b0;
    state_n  = state;
    ir_n     = IR;
    step_n   = STEP;
    int_n    = int_type;

    case (MC_IN.STATE_CTRL)
      SC_END:     fetch = 1'b1;
      SC_SKIP_W8: sum = {1'b0, STEP} + (W8 ? 5'd2 : 5'd1);
      SC_SKIP_DL: sum = {1'b0, STEP} + (DL_NZ ? 5'd1 : 5'd2);
      SC_BRANCH:  fetch = ~BR_TAKEN;
`ifdef P65816_WAI_STP_EN
      SC_WAI:     go_wait = 1'b1;
      SC_STP:     go_stop = 1'b1;
`else
      SC_WAI, SC_STP: fetch = 1'b1;
`endif
      default: ;
    endcase

    if (sum[4])
      fetch = 1'b1;

    // Outside RUN the ROM word is ignored; only a WAI wake-up can fetch.
    if (state != S_RUN) begin
      go_wait = 1'b0;
      go_stop = 1'b0;
      fetch   = (state == S_WAIT) & wake;
    end

    if (RST) begin
      state_n = S_RUN;
      ir_n    = 8'h00;
      step_n  = 4'd0;
      int_n   = INT_RESET;
    end else if (advance) begin
      if (fetch) begin
        state_n  = S_RUN;
        step_n   = 4'd0;
        int_n    = int_sel;
        ir_n     = (int_sel == INT_NONE) ? DATA_IN : 8'h00;
        take_nmi = (int_sel == INT_NMI);
      end else if (go_wait) begin
        state_n = S_WAIT;
      end else if (go_stop) begin
        state_n = S_STOP;
      end else if (state == S_RUN) begin
        step_n = sum[3:0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_RUN;
      IR       <= 8'h00;
      STEP     <= 4'd0;
      int_type <= INT_RESET;
    end else begin
      state    <= state_n;
      IR       <= ir_n;
      STEP     <= step_n;
      int_type <= int_n;
    end
  end

  assign MA       = ADDR_W'({ir_n, step_n});
  assign MC       = (!RDY || state != S_RUN) ? MC_NOP : MC_IN;
  assign SYNC     = fetch & ~RST;
  assign INT_TYPE = int_type;

`ifdef P65816_WAI_STP_EN
  assign WAITING = (state == S_WAIT);
  assign HALTED  = (state == S_STOP);
`else
  assign WAITING = 1'b0;
  assign HALTED  = 1'b0;
`endif

endmodule

// File: doc/p65816_mcode_seq.md
# p65816_mcode_seq

Microcode sequencer for the 65C816 core. Walks the per-opcode microinstruction stream by driving the microcode ROM address. Interprets the `STATE_CTRL` field of each `MCode_r` word to choose the next step. Handles opcode capture, interrupt insertion, RDY/CE stalls and WAI/STP. Sits between the bus interface (opcode byte, RDY) and the microcode ROM, whose output fans out to the datapath.

## Interface
- `ADDR_W`, default 12: ROM address width; address is `{IR[7:0], STEP[3:0]}`.
- `CLK` in 1: system clock.
- `RST` in 1: synchronous, active-high reset.
- `CE` in 1: CPU cycle enable; state advances only when `CE & RDY`.
- `RDY` in 1: bus ready; low stalls the current microinstruction.
- `DATA_IN` in 8: bus read data; holds the opcode byte on a SYNC cycle.
- `MC_IN` in 55: `MCode_r` word from the ROM for the current `{IR, STEP}`.
- `W8` in 1: current width is 8-bit (M or X flag as selected by the microcode).
- `DL_NZ` in 1: direct-page low byte is non-zero.
- `BR_TAKEN` in 1: branch condition result for the current opcode.
- `NMI_N` in 1, `IRQ_N` in 1: interrupt lines, already synchronised.
- `I_FLAG` in 1: P.I.
- `MA` out ADDR_W: next ROM address (combinational; the ROM registers it).
- `MC` out 55: `MC_IN` forced to `MC_NOP` when stalled or halted.
- `IR` out 8, `STEP` out 4: current opcode and step.
- `SYNC` out 1: this cycle is an opcode fetch.
- `INT_TYPE` out 2: 0 none, 1 IRQ, 2 NMI, 3 RESET.
- `WAITING` out 1, `HALTED` out 1: WAI and STP states.

## Operation
- FSM states: `RUN`, `WAIT`, `STOP`.
- `RST`:
  - State `RUN`, `IR=8'h00`, `STEP=0`, `INT_TYPE=3`.
  - Clears the NMI latch and sets the NMI edge detector's previous-value register to 1.
  - Outputs `SYNC=0`, `WAITING=0`, `HALTED=0`, `MA=0`.
  - The BRK microcode then executes as the reset sequence.
- `STATE_CTRL` decode, applied on an advance (`CE & RDY`):
  - 0 NEXT: `STEP+1`.
  - 1 END: the cycle is also the opcode fetch, so `SYNC=1`. On advance, `STEP=0` and IR is loaded as follows:
    - NMI latched: IR=00, `INT_TYPE=2`.
    - Else `!IRQ_N & !I_FLAG`: IR=00, `INT_TYPE=1`.
    - Else IR=`DATA_IN`, `INT_TYPE=0`.
  - 2 SKIP_W8: `STEP+2` if `W8`, else `STEP+1`.
  - 3 SKIP_DL: `STEP+1` if `DL_NZ`, else `STEP+2`.
  - 4 BRANCH: `STEP+1` if `BR_TAKEN`, else behaves as END.
  - 5 WAI: enter `WAIT`.
  - 6 STP: enter `STOP`.
  - 7 reserved: behaves as NEXT.
- Step overflow: any computed step above 15 behaves as END. The 4-bit counter never wraps into step 0 of the same opcode.
- NMI latch:
  - Set on a falling edge of `NMI_N`, sampled every clock regardless of `CE`.
  - Cleared when the NMI is taken at END.
  - A set and a clear in the same cycle leave it set only if a new edge arrived.
- `WAIT`:
  - `MC=MC_NOP`, `WAITING=1`.
  - Leaves on a latched NMI or `!IRQ_N` (I flag ignored) at the next `CE`.
  - Then performs END semantics with `SYNC=1` for that cycle.
  - If `I_FLAG=1` and only IRQ is pending, loads IR from `DATA_IN`; no vectoring.
- `STOP`: `MC=MC_NOP`, `HALTED=1`. Only `RST` exits.
- Stall: when `!(CE & RDY)`:
  - `IR`, `STEP` and state are held.
  - `MA` re-presents the current address.
  - `MC` is forced to `MC_NOP` only when `RDY=0`, so no datapath side effects repeat.
- Simultaneous events: `RST` beats everything; NMI beats IRQ; END beats a same-cycle IRQ deassert, because sampling happens at the advancing edge.

## Timing
- `MA` is combinational from the registered state plus `MC_IN`. `MC_IN` for `{IR, STEP}` is valid in the same cycle those registers hold that value, so lookup latency is effectively 0 from the sequencer's view.
- Opcode latency: the `DATA_IN` sampled at the END edge is executing (`STEP=0`) on the next cycle.
- IRQ/NMI recognition: interrupts are sampled only at the END edge. An NMI edge arriving at least 1 cycle before END is taken at that END.

## Configuration
- `P65816_WAI_STP_EN`:
  - Defined: WAI/STP behave as above.
  - Undefined: codes 5/6 behave as END, the `WAIT`/`STOP` states are not built, and `WAITING`/`HALTED` are tied 0.

## Structure
- Package `P65816` gains:
  - `typedef enum logic [2:0] StateCtrl_e` for codes 0–7.
  - `typedef enum logic [1:0] IntType_e`.
  - `typedef enum logic [1:0] SeqState_e`.
  - Constant `MC_NOP` of type `MCode_r`.
- One natural sub-module: `p65816_int_latch`, which does NMI edge detection, latching and priority selection.

## Test plan
- Reset: hold `RST` 2 cycles → `IR=00`, `STEP=0`, `INT_TYPE=3`, `SYNC=0`; with ROM steps NEXT, NEXT, END, `SYNC=1` is seen on the 3rd cycle.
- Opcode load: END with `DATA_IN=8'hA9` → next cycle `IR=A9`, `STEP=0`, `MA=12'hA90`.
- Conditional skip: `STATE_CTRL=2` at step 1 with `W8=1` → `STEP=3`; repeat with `W8=0` → `STEP=2`.
- Branch: `STATE_CTRL=4`, `BR_TAKEN=0` → `SYNC=1` that cycle, opcode reload on next advance.
- Interrupt priority: NMI edge and `IRQ_N=0` both pending at END → `IR=00`, `INT_TYPE=2`; at the next END with IRQ still low and `I_FLAG=0` → `INT_TYPE=1`.
- Stall and WAI:
  - `RDY=0` for 3 cycles mid-instruction → `STEP` held, `MC=MC_NOP`.
  - WAI then `IRQ_N=0` with `I_FLAG=1` → `WAITING` goes 1→0, `IR=DATA_IN`, `INT_TYPE=0`.
